fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 The module SHALL have no parameters; memory bound 1024 bytes and all encodings SHALL be fixed constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PC  input  64  address of the instruction being fetched.
REQ-005 current_instruction  input  [0:79]  10 instruction bytes at PC..PC+9; byte k = bits [8k:8k+7], byte 0 at bits [0:7].
REQ-006 icode  output  4  byte0 bits [0:3].
REQ-007 ifun  output  4  byte0 bits [4:7].
REQ-008 rA  output  4  register specifier A; 0xF when absent.
REQ-009 rB  output  4  register specifier B; 0xF when absent.
REQ-010 valC  output  64  constant word; 0 when absent.
REQ-011 valP  output  64  next sequential PC.
REQ-012 halt_prog  output  1  halt decoded now or previously latched.
REQ-013 is_instruction_valid  output  1  legal icode/ifun pair.
REQ-014 pcvalid  output  1  PC inside instruction memory.

Function
REQ-015 Decode SHALL be purely combinational from PC and current_instruction; zero-cycle latency.
REQ-016 Lengths: halt(0), nop(1), ret(9) = 1 byte; cmovXX(2), OPq(6), pushq(A), popq(B) = 2; jXX(7), call(8) = 9; irmovq(3), rmmovq(4), mrmovq(5) = 10.
REQ-017 Register byte (byte1) SHALL drive rA = bits[8:11], rB = bits[12:15] for icodes 2,3,4,5,6,A,B; otherwise both 0xF.
REQ-018 For icodes 3,4,5, valC SHALL be bytes 2..9 little-endian (byte2 = valC[7:0], byte9 = valC[63:56]).
REQ-019 For icodes 7,8, valC SHALL be bytes 1..8 little-endian.
REQ-020 valP SHALL be PC + length, 64-bit modulo 2^64.
REQ-021 is_instruction_valid SHALL be 1 iff: icode 0,1,3,4,5,8,9,A,B with ifun 0; icode 2 or 7 with ifun 0..6; or icode 6 with ifun 0..3.
REQ-022 An invalid instruction SHALL use length 1, rA = rB = 0xF, and valC = 0.
REQ-023 pcvalid SHALL be 1 iff PC <= 1023.
REQ-024 A sticky register "halted" SHALL set on a rising edge where icode = 0, ifun = 0, and pcvalid = 1.
REQ-025 halt_prog SHALL equal halted OR (icode = 0 AND ifun = 0).
REQ-026 While halted = 1, valP SHALL equal PC so the PC holds; all other outputs keep decoding normally.
REQ-027 An invalid instruction or invalid PC SHALL NOT set halted; both are reported through the status outputs only.

Reset
REQ-028 With reset high at a rising edge, halted SHALL become 0.
REQ-029 Reset SHALL take priority over a simultaneous halt-set condition.
REQ-030 Combinational outputs are not reset-gated; after reset, valP = PC + length.
REQ-031 Reset asserted mid-halt SHALL release the PC hold on the following cycle.

Structure
REQ-032 A shared package SHALL hold the icode constants (IHALT..IPOPQ), the RNONE = 0xF constant, the instruction-length constants, and the memory size 1024.
REQ-033 One sub-module, fetch_decoder, SHALL hold the combinational split, length, and validity logic; the top SHALL hold the halted register and the valP mux.

Verification
REQ-034 Bytes 60 03 at PC=0 -> icode=6, ifun=0, rA=0, rB=3, valC=0, valP=2, valid=1, pcvalid=1.
REQ-035 Bytes 20 03 at PC=2 -> icode=2, rA=0, rB=3, valP=4.
REQ-036 Bytes 40 03 00 00 00 00 00 00 00 0F at PC=4 -> icode=4, rA=0, rB=3, valC=0x0F00000000000000, valP=14.
REQ-037 Bytes 10 at PC=14 -> valP=15; then 00 at PC=16 -> halt_prog=1, valP=17; after the next edge valP=16 and halt_prog stays 1 until reset, after which valP=17 again.
REQ-038 Byte C0 -> is_instruction_valid=0, valP=PC+1; byte 64 -> invalid; PC=1024 -> pcvalid=0, and halt bytes at that PC do not set halted.
REQ-039 Byte 70 with bytes 1..8 = 01..08 -> valC=0x0807060504030201, valP=PC+9, rA=rB=0xF.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared icode, register and length constants for the Y86-64 fetch stage.
// Ports: none (package).
package fetch_pkg;
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] LEN_1   = 4'd1;
    localparam logic [3:0] LEN_2   = 4'd2;
    localparam logic [3:0] LEN_9   = 4'd9;
    localparam logic [3:0] LEN_10  = 4'd10;
    localparam logic [63:0] MEM_SIZE = 64'd1024;
endpackage

// File: rtl/fetch_decoder.sv
// fetch_decoder: combinational split of the instruction bytes into fields, length and validity.
// Ports: current_instruction (10 bytes, byte 0 at bits [0:7]) in; icode, ifun, rA, rB, valC, len, valid out.
module fetch_decoder
    import fetch_pkg::*;
(
    input  logic [0:79] current_instruction,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [3:0]  len,
    output logic        valid
);
    logic [63:0] c_from2;
    logic [63:0] c_from1;
    logic        has_reg;
    always_comb begin
        icode = current_instruction[0:3];
        ifun  = current_instruction[4:7];
        // little-endian constant words starting at byte 2 or byte 1
        c_from2 = '0;
        c_from1 = '0;
        for (int k = 0; k < 8; k++) begin
            c_from2[8*k +: 8] = current_instruction[16 + 8*k +: 8];
            c_from1[8*k +: 8] = current_instruction[8 + 8*k +: 8];
        end
        valid = ((icode inside {IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ}) && ifun == 4'd0)
             || ((icode inside {IRRMOVQ, IJXX}) && ifun <= 4'd6)
             || (icode == IOPQ && ifun <= 4'd3);
        has_reg = valid && (icode inside {IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IPUSHQ, IPOPQ});
        rA = has_reg ? current_instruction[8:11] : RNONE;
        rB = has_reg ? current_instruction[12:15] : RNONE;
        valC = !valid ? 64'd0
             : (icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ}) ? c_from2
             : (icode inside {IJXX, ICALL}) ? c_from1 : 64'd0;
        len = !valid ? LEN_1
            : (icode inside {IRRMOVQ, IOPQ, IPUSHQ, IPOPQ}) ? LEN_2
            : (icode inside {IJXX, ICALL}) ? LEN_9
            : (icode inside {IIRMOVQ, IRMMOVQ, IMRMOVQ}) ? LEN_10 : LEN_1;
    end
endmodule

// File: rtl/fetch.sv
// fetch: Y86-64 fetch stage with sticky halt register that freezes the next-PC once halt is reached.
// Ports: clk, reset (sync, active-high), PC, current_instruction in; icode, ifun, rA, rB, valC, valP,
//        halt_prog, is_instruction_valid, pcvalid out.
module fetch
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC,
    input  logic [0:79] current_instruction,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        halt_prog,
    output logic        is_instruction_valid,
    output logic        pcvalid
);
    logic [3:0] len;
    logic       halt_now;
    logic       halted_d;
    logic       halted_q;

    fetch_decoder u_dec (
        .current_instruction(current_instruction),
        .icode(icode),
        .ifun(ifun),
        .rA(rA),
        .rB(rB),
        .valC(valC),
        .len(len),
        .valid(is_instruction_valid)
    );

    always_comb begin
        pcvalid   = PC < MEM_SIZE;
        halt_now  = icode == IHALT && ifun == 4'd0;
        // only a halt fetched from a legal address latches
        halted_d  = halted_q | (halt_now & pcvalid);
        halt_prog = halted_q | halt_now;
        valP      = halted_q ? PC : PC + {60'd0, len};
    end

    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed and randomized checks of fetch against a spec-level reference model.
module tb_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] PC;
    logic [0:79] current_instruction;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        halt_prog, is_instruction_valid, pcvalid;

    int checks = 0;
    int failures = 0;
    logic [7:0] b [10];
    logic m_halted;

    fetch dut (
        .clk(clk),
        .reset(reset),
        .PC(PC),
        .current_instruction(current_instruction),
        .icode(icode),
        .ifun(ifun),
        .rA(rA),
        .rB(rB),
        .valC(valC),
        .valP(valP),
        .halt_prog(halt_prog),
        .is_instruction_valid(is_instruction_valid),
        .pcvalid(pcvalid)
    );

    always #5 clk = ~clk;

    task chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task ld(input logic [79:0] v);
        for (int k = 0; k < 10; k++) b[k] = v[79-8*k -: 8];
    endtask

    // Apply PC/bytes/reset, check all outputs mid-cycle, then advance one edge.
    task step(input logic [63:0] pc, input logic rst);
        int ic, fn, l;
        logic v, hn, pv;
        logic [3:0] ra, rb;
        logic [63:0] vc;
        PC = pc;
        reset = rst;
        for (int k = 0; k < 10; k++) current_instruction[8*k +: 8] = b[k];
        ic = int'(b[0][7:4]);
        fn = int'(b[0][3:0]);
        v = ((ic inside {0, 1, 3, 4, 5, 8, 9, 10, 11}) && fn == 0)
         || ((ic == 2 || ic == 7) && fn <= 6) || (ic == 6 && fn <= 3);
        if (!v) l = 1;
        else if (ic inside {0, 1, 9}) l = 1;
        else if (ic inside {2, 6, 10, 11}) l = 2;
        else if (ic inside {7, 8}) l = 9;
        else l = 10;
        ra = (v && (ic inside {2, 3, 4, 5, 6, 10, 11})) ? b[1][7:4] : 4'hF;
        rb = (v && (ic inside {2, 3, 4, 5, 6, 10, 11})) ? b[1][3:0] : 4'hF;
        vc = 0;
        for (int k = 0; k < 8; k++) begin
            if (v && ic >= 3 && ic <= 5) vc = vc + (64'(b[k+2]) << (8*k));
            if (v && (ic == 7 || ic == 8)) vc = vc + (64'(b[k+1]) << (8*k));
        end
        hn = ic == 0 && fn == 0;
        pv = pc <= 64'd1023;
        #2;
        chk("icode", icode, 64'(ic));
        chk("ifun", ifun, 64'(fn));
        chk("rA", rA, ra);
        chk("rB", rB, rb);
        chk("valC", valC, vc);
        chk("valP", valP, m_halted ? pc : pc + 64'(l));
        chk("halt_prog", halt_prog, m_halted | hn);
        chk("valid", is_instruction_valid, v);
        chk("pcvalid", pcvalid, pv);
        @(posedge clk);
        m_halted = rst ? 1'b0 : (m_halted | (hn & pv));
        #1;
    endtask

    initial begin
        logic [63:0] pc;
        int r;
        reset = 1'b1;
        PC = 0;
        current_instruction = '0;
        ld(80'h10000000000000000000);
        @(posedge clk);
        #1;
        m_halted = 1'b0;
        step(64'd0, 1'b1);
        ld(80'h60030000000000000000); step(64'd0, 1'b0);
        chk("d034_valP", valP, 64'd2);
        ld(80'h20030000000000000000); step(64'd2, 1'b0);
        ld(80'h4003000000000000000F); step(64'd4, 1'b0);
        ld(80'h10000000000000000000); step(64'd14, 1'b0);
        ld(80'h00000000000000000000); step(64'd16, 1'b0);
        step(64'd16, 1'b0);
        ld(80'h10000000000000000000); step(64'd20, 1'b0);
        ld(80'h00000000000000000000); step(64'd16, 1'b1);
        step(64'd16, 1'b0);
        step(64'd16, 1'b1);
        ld(80'hC0000000000000000000); step(64'd30, 1'b0);
        ld(80'h64000000000000000000); step(64'd32, 1'b0);
        ld(80'h00000000000000000000); step(64'd1024, 1'b0);
        step(64'd1024, 1'b0);
        step(64'd1023, 1'b0);
        step(64'd1023, 1'b1);
        ld(80'h70010203040506070809); step(64'd40, 1'b0);
        ld(80'h3012AABBCCDDEEFF0011); step(64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
            b[0][3:0] = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            if (b[0][7:4] == 4'h0 && $urandom_range(0, 3) != 0) b[0][7:4] = 4'h1;
            r = $urandom_range(0, 3);
            pc = (r == 0) ? {$urandom, $urandom}
               : (r == 1) ? 64'($urandom_range(1020, 1028))
               : 64'($urandom_range(0, 1023));
            step(pc, $urandom_range(0, 7) == 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
